// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC and applies ID-resolved
// stall/flush/redirects. A BOOT/RUN/HALT FSM covers the startup cycle and halt/fault.
module fetch_stage #(
   parameter int          IMEM_WORDS = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic [1:0]  jump_sel,
   input  logic [25:0] jump_index,
   input  logic [31:0] jr_addr,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic        halted,
   output logic        fault
);

   localparam logic [31:0] PC_LIMIT  = 32'(IMEM_WORDS * 4);
   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        fault_q, fault_d;

   logic [31:0] br_tgt, j_tgt, tgt;
   logic        redirect, jr_bad;

   // Targets are formed from the instruction sitting in ID, hence id_pc4 not the live PC.
   assign br_tgt   = pc4_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};
   assign j_tgt    = {pc4_q[31:28], jump_index, 2'b00};
   assign redirect = valid_q && (branch_taken || (jump_sel != 2'b00));
   assign jr_bad   = (jump_sel == 2'b10) && (jr_addr[1:0] != 2'b00);

   always_comb begin
      case (jump_sel)
         2'b00:   tgt = br_tgt;
         2'b10:   tgt = jr_addr;
         default: tgt = j_tgt;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_BOOT;
         pc_q     <= RESET_PC;
         instr_q  <= 32'h0;
         pc4_q    <= 32'h0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc4_q    <= pc4_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc4_d    = pc4_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (pc_q >= PC_LIMIT) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
               fault_d  = 1'b1;
               valid_d  = 1'b0;
            end else if (stall) begin
               // ID re-presents any redirect once the stall clears, so it is ignored here.
               if (flush) begin
                  valid_d = 1'b0;
                  instr_d = 32'h0;
               end
            end else if (redirect) begin
               pc_d    = tgt;
               valid_d = 1'b0;
               instr_d = 32'h0;
               if (jr_bad) begin
                  // Misaligned jr: keep the bad address in the PC for post-mortem.
                  state_d  = S_HALT;
                  halted_d = 1'b1;
                  fault_d  = 1'b1;
               end
            end else if (imem_data == HALT_WORD) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
               valid_d  = 1'b0;
            end else begin
               instr_d = flush ? 32'h0 : imem_data;
               pc4_d   = pc_q + 32'd4;
               valid_d = ~flush;
               pc_d    = pc_q + 32'd4;
            end
         end
         default: ;
      endcase
   end

   assign imem_addr = pc_q;
   assign id_instr  = instr_q;
   assign id_pc4    = pc4_q;
   assign id_valid  = valid_q;
   assign halted    = halted_q;
   assign fault     = fault_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS datapath, sitting directly upstream of `control`, `reg_file` and `sign_extend`. It owns the PC and drives the `instruction_memory` read address. It latches the fetched word with its PC+4 into the IF/ID register, and applies stall, flush and branch/jump/jr redirects resolved in ID. A small state machine handles boot, normal fetch and halt/fault.

## Interface
- `IMEM_WORDS`, 64: instruction memory depth in 32-bit words; legal PCs are 0 .. IMEM_WORDS*4-4.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID register (load-use hazard from ID).
- `flush`  in  1  squash IF/ID at the next edge (write NOP, id_valid=0).
- `branch_taken`  in  1  ID branch resolved taken (beq/bne and zero logic).
- `branch_offset`  in  16  ID instruction [15:0].
- `jump_sel`  in  2  00 sequential/branch, 01 j, 10 jr, 11 jal (same target as j).
- `jump_index`  in  26  ID instruction [25:0].
- `jr_addr`  in  32  rs value from reg_file read port 1.
- `imem_addr`  out  32  current PC, combinational to instruction_memory.
- `imem_data`  in  32  instruction word at imem_addr, combinational.
- `id_instr`  out  32  IF/ID instruction.
- `id_pc4`  out  32  IF/ID PC+4.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  halt state entered.
- `fault`  out  1  halt was caused by an error.

## Operation
- States: BOOT, RUN, HALT. Reset: state=BOOT, pc=RESET_PC, id_instr=0, id_pc4=0, id_valid=0, halted=0, fault=0.
- BOOT: exactly one cycle; pc and IF/ID hold, id_valid stays 0; next state RUN.
- RUN, per edge, first matching rule wins:
  1. pc >= IMEM_WORDS*4: HALT, fault=1, halted=1, id_valid<=0, pc holds.
  2. stall=1: pc, id_instr, id_pc4 hold; redirect inputs ignored (ID re-presents them); if flush=1, id_valid<=0 and id_instr<=0.
  3. Redirect accepted (id_valid=1 and (branch_taken=1 or jump_sel!=00)): pc<=target; id_valid<=0, id_instr<=0 (fetched wrong-path word squashed).
  4. imem_data == 32'hFC00_0000 (opcode 111111, HALT): HALT, halted=1, fault=0, id_valid<=0, pc holds at halt address.
  5. Sequential: id_instr<=imem_data, id_pc4<=pc+4, id_valid<=~flush (id_instr<=0 if flush), pc<=pc+4.
- Target selection when jump_sel!=00 overrides branch_taken:
  - 01/11: {id_pc4[31:28], jump_index, 2'b00}.
  - 10: jr_addr.
  - 00 with branch_taken: id_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}, mod 2^32.
- jr target with jr_addr[1:0]!=00: pc<=jr_addr (kept for debug), HALT, fault=1, halted=1, id_valid<=0.
- Redirect inputs are ignored when id_valid=0.
- HALT: every register holds; only reset exits.
- All PC arithmetic is 32-bit unsigned wrap.

## Timing
- imem_addr equals pc with zero latency; the fetched word is visible on id_instr one edge later.
- Redirect penalty is one bubble: redirect in cycle N, target word in IF/ID after edge N+1.
- First valid id_instr appears after the second rising edge following reset release (BOOT, then first fetch).
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- halted and fault are registered; they rise at the edge that enters HALT.

## Test plan
- Reset release, mem[0]=32'h0022_1820, mem[1]=32'h0022_1822 -> edge1 BOOT id_valid=0; edge2 id_instr=32'h0022_1820, id_pc4=4; edge3 id_instr=32'h0022_1822, id_pc4=8.
- With id_pc4=8 and id_valid=1, drive branch_taken=1, branch_offset=16'hFFFE -> pc=0 next edge, id_valid=0; following edge id_instr=mem[0]; then repeat with jump_sel=01, jump_index=26'h10 -> pc=32'h40.
- stall=1 for 3 cycles with branch_taken=1 -> pc and id_instr unchanged, no redirect; stall=1 with flush=1 -> id_valid=0, pc held.
- jump_sel=10, jr_addr=32'h14 -> pc=32'h14; then jr_addr=32'h16 -> pc=32'h16, halted=1, fault=1, pc frozen over 5 cycles.
- mem[3]=32'hFC00_0000 in a straight-line program -> after fetching pc=12: halted=1, fault=0, pc=12, id_valid=0; reset -> all outputs 0, pc=RESET_PC.
- IMEM_WORDS=4 straight-line code -> at pc=16: halted=1, fault=1; async reset asserted between edges clears state immediately.
